region_attr_table: RTL and testbench
====================================

# region_attr_table

Runtime-programmable memory-region attribute table; successor to the static non-idempotent/execute/cached region rules fixed in the core configuration. Holds `NrRules` base/length rules with per-rule attributes and lock bits. Serves `NrPorts` independent pipelined lookup ports, one per requester, e.g. fetch and LSU. Sits between the CSR file (programming side) and the frontend/LSU (lookup side).

## Interface
- `NrRules`, 8: number of rule slots, 1..64.
- `NrPorts`, 2: number of lookup ports, 1..4.
- `AddrWidth`, 64: address, base and length width.
- `DefaultAttr`, 3'b001: attributes `{nonidem, cached, exec}` returned on miss.
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `cfg_req_i` in 1: configuration write strobe, single cycle.
- `cfg_idx_i` in `$clog2(NrRules)`: rule slot index.
- `cfg_base_i` in `AddrWidth`: rule base address.
- `cfg_len_i` in `AddrWidth`: rule length in bytes; 0 disables the rule.
- `cfg_attr_i` in 3: `{nonidem, cached, exec}`.
- `cfg_lock_i` in 1: set the lock bit with this write.
- `cfg_clear_i` in 1: clear all unlocked rules.
- `cfg_err_o` out 1: pulses when a write targeted a locked slot.
- `lk_valid_i` in `NrPorts`: lookup request valid.
- `lk_ready_o` out `NrPorts`: lookup request ready.
- `lk_addr_i` in `NrPorts*AddrWidth`: lookup addresses.
- `rsp_valid_o` out `NrPorts`: response valid.
- `rsp_ready_i` in `NrPorts`: response ready.
- `rsp_attr_o` out `NrPorts*3`: resolved attributes.
- `rsp_hit_o` out `NrPorts`: a rule matched.
- `rsp_idx_o` out `NrPorts*$clog2(NrRules)`: index of the matching rule; 0 on miss.
- `miss_cnt_o` out `NrPorts*32`: per-port miss counters. Present only with the configuration macro.

## Operation
- **Reset:**
  - All rules have base = 0, len = 0, attr = 0 and lock = 0.
  - All outputs are 0: `rsp_valid_o`, `rsp_attr_o`, `rsp_hit_o`, `rsp_idx_o`, `cfg_err_o`, `miss_cnt_o`.
  - `lk_ready_o` is all-ones.
- **Config write:**
  - On `cfg_req_i` with slot `cfg_idx_i` unlocked, base, len, attr and lock are written at the clock edge.
  - If the slot is locked, nothing is written and `cfg_err_o` is 1 in the next cycle.
  - Lock is sticky. It clears only on reset.
- **Clear:**
  - `cfg_clear_i` zeroes base, len and attr of every unlocked slot.
  - If a clear and a write occur in the same cycle, the write to its slot wins.
- **Match rule:**
  - A rule matches when `len != 0`, `addr >= base`, and `{1'b0,addr} < {1'b0,base} + {1'b0,len}`. The sum is computed in `AddrWidth+1` bits, so a region ending at 2^AddrWidth is legal and never wraps.
  - Priority: the lowest matching index wins.
  - Miss: attr = `DefaultAttr`, hit = 0, idx = 0.
- **Per-port handshake:**
  - Each port has a one-entry output register.
  - `lk_ready_o[p] = !rsp_valid_o[p] || rsp_ready_i[p]`.
  - A request is accepted when `lk_valid_i[p] && lk_ready_o[p]`.
  - The response register updates on acceptance.
  - `rsp_valid_o` clears when the response is consumed and no new request is accepted.
  - A response is held stable while `rsp_valid_o && !rsp_ready_i`.
- Ports are fully independent. There is no cross-port stalling.

## Timing
- Lookup latency is 1 cycle: accept at edge N, response valid after edge N.
- Throughput is 1 lookup per port per cycle when `rsp_ready_i` is held high.
- A lookup in the same cycle as a config write or clear sees the pre-write table. The new rule is visible to requests accepted from the next cycle.
- `cfg_err_o` is a registered single-cycle pulse.
- Asynchronous reset mid-operation:
  - Drops all pending responses immediately.
  - Unlocks and clears all rules.
  - Zeroes all counters.

## Configuration
- `REGION_ATTR_MISS_CNT_EN`:
  - **Defined:** `miss_cnt_o` exists. Each port has a 32-bit counter that increments on every accepted lookup that misses. It saturates at 32'hFFFF_FFFF and is reset to 0.
  - **Undefined:** the port and counters are absent. All other behaviour is identical.

## Test plan
- **Reset defaults:** assert `rst_ni`=0 mid-traffic, then lookup 0x8000_0000 on port 0. Required: `rsp_hit_o`=0, attr=3'b001, response 1 cycle after acceptance.
- **Priority:** program rule 2 = {0x8000_0000, len 0x4000_0000, attr 3'b011} and rule 5 = {0x8000_0000, len 0x1000, attr 3'b100}. Lookup 0x8000_0800. Required: idx=2, attr=3'b011.
- **Boundaries:** rule 0 = {0x1_0000, len 0x1_0000}. Lookups and required results:
  - 0x1_0000: hit.
  - 0x1_FFFF: hit.
  - 0x2_0000: miss.
  - Rule 1 = {0xFFFF_FFFF_FFFF_F000, len 0x1000}, lookup 0xFFFF_FFFF_FFFF_FFFF: hit, no wrap.
- **Lock:** write rule 3 with lock=1, then rewrite it with attr 3'b000, then assert `cfg_clear_i`.
  - Required: `cfg_err_o` pulses once, on the rewrite.
  - Required: rule 3 attr is unchanged after both the rewrite and the clear.
  - Required: unlocked rules are cleared.
- **Backpressure and concurrency:**
  - Port 1 `rsp_ready_i`=0 for 4 cycles with `lk_valid_i` high. Required: `lk_ready_o[1]`=0 and the response is stable; port 0 keeps 1 lookup/cycle.
  - Write rule 0 in the same cycle as a port 0 lookup in its range. Required: the lookup returns the old attr; the next lookup returns the new attr.
- **Miss counter (macro defined):** 10 missing and 5 hitting lookups on port 0. Required: `miss_cnt_o[0]`=10 and port 1 count = 0. Force the counter to 32'hFFFF_FFFF; a further miss must leave it at 32'hFFFF_FFFF.

Source files
------------

// File: rtl/region_attr_table.sv
// region_attr_table
//
// Runtime-programmable memory-region attribute table. It holds NrRules
// base/length rules, each with attributes {nonidem, cached, exec} and a sticky
// lock bit. It serves NrPorts independent lookup ports, and each port has a
// one-entry response register.
//
// Optional feature macro: REGION_ATTR_MISS_CNT_EN adds per-port saturating
// 32-bit miss counters on miss_cnt_o.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   cfg_req_i             single-cycle rule write strobe
//   cfg_idx_i             rule slot to write
//   cfg_base_i/cfg_len_i  rule base address and length (len 0 disables the rule)
//   cfg_attr_i            {nonidem, cached, exec}
//   cfg_lock_i            lock the slot with this write
//   cfg_clear_i           clear every unlocked slot
//   cfg_err_o             one-cycle pulse after a write to a locked slot
//   lk_valid_i/lk_ready_o per-port lookup request handshake
//   lk_addr_i             per-port lookup addresses, port p at [p*AddrWidth +: AddrWidth]
//   rsp_valid_o/rsp_ready_i per-port response handshake
//   rsp_attr_o/rsp_hit_o/rsp_idx_o per-port resolved lookup result
//   miss_cnt_o            per-port miss counters (macro builds only)
module region_attr_table #(
    parameter int unsigned NrRules     = 8,
    parameter int unsigned NrPorts     = 2,
    parameter int unsigned AddrWidth   = 64,
    parameter logic [2:0]  DefaultAttr = 3'b001,
    localparam int unsigned IdxW       = (NrRules > 1) ? $clog2(NrRules) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         cfg_req_i,
    input  logic [IdxW-1:0]              cfg_idx_i,
    input  logic [AddrWidth-1:0]         cfg_base_i,
    input  logic [AddrWidth-1:0]         cfg_len_i,
    input  logic [2:0]                   cfg_attr_i,
    input  logic                         cfg_lock_i,
    input  logic                         cfg_clear_i,
    output logic                         cfg_err_o,
    input  logic [NrPorts-1:0]           lk_valid_i,
    output logic [NrPorts-1:0]           lk_ready_o,
    input  logic [NrPorts*AddrWidth-1:0] lk_addr_i,
    output logic [NrPorts-1:0]           rsp_valid_o,
    input  logic [NrPorts-1:0]           rsp_ready_i,
    output logic [NrPorts*3-1:0]         rsp_attr_o,
    output logic [NrPorts-1:0]           rsp_hit_o,
    output logic [NrPorts*IdxW-1:0]      rsp_idx_o
`ifdef REGION_ATTR_MISS_CNT_EN
    , output logic [NrPorts*32-1:0]      miss_cnt_o
`endif
);

    // Rule table
    logic [AddrWidth-1:0] rule_base_q [NrRules];
    logic [AddrWidth-1:0] rule_base_d [NrRules];
    logic [AddrWidth-1:0] rule_len_q  [NrRules];
    logic [AddrWidth-1:0] rule_len_d  [NrRules];
    logic [2:0]           rule_attr_q [NrRules];
    logic [2:0]           rule_attr_d [NrRules];
    logic [NrRules-1:0]   rule_lock_q, rule_lock_d;
    logic                 cfg_err_q, cfg_err_d;

    // Per-port response registers
    logic [NrPorts-1:0]           rsp_valid_q, rsp_valid_d;
    logic [NrPorts-1:0][2:0]      rsp_attr_q, rsp_attr_d;
    logic [NrPorts-1:0]           rsp_hit_q, rsp_hit_d;
    logic [NrPorts-1:0][IdxW-1:0] rsp_idx_q, rsp_idx_d;

    // Combinational lookup results against the current (pre-write) table
    logic [NrPorts-1:0]           lk_hit;
    logic [NrPorts-1:0][2:0]      lk_attr;
    logic [NrPorts-1:0][IdxW-1:0] lk_idx;
    logic [NrPorts-1:0]           lk_accept;

    // The end of the region is formed one bit wider than the address, so a
    // region that ends exactly at 2^AddrWidth does not wrap to zero.
    function automatic logic rule_match(input logic [AddrWidth-1:0] addr,
                                        input logic [AddrWidth-1:0] base,
                                        input logic [AddrWidth-1:0] len);
        logic [AddrWidth:0] limit;
        limit = {1'b0, base} + {1'b0, len};
        return (len != '0) && (addr >= base) && ({1'b0, addr} < limit);
    endfunction

    // Table update. A write to an unlocked slot takes precedence over a
    // clear issued in the same cycle. Locked slots ignore both.
    always_comb begin
        rule_lock_d = rule_lock_q;
        cfg_err_d   = 1'b0;
        for (int r = 0; r < int'(NrRules); r++) begin
            rule_base_d[r] = rule_base_q[r];
            rule_len_d[r]  = rule_len_q[r];
            rule_attr_d[r] = rule_attr_q[r];
            if (cfg_req_i && (cfg_idx_i == IdxW'(r)) && rule_lock_q[r]) begin
                cfg_err_d = 1'b1;
            end
            if (!rule_lock_q[r]) begin
                if (cfg_req_i && (cfg_idx_i == IdxW'(r))) begin
                    rule_base_d[r] = cfg_base_i;
                    rule_len_d[r]  = cfg_len_i;
                    rule_attr_d[r] = cfg_attr_i;
                    rule_lock_d[r] = cfg_lock_i;
                end else if (cfg_clear_i) begin
                    rule_base_d[r] = '0;
                    rule_len_d[r]  = '0;
                    rule_attr_d[r] = '0;
                end
            end
        end
    end

    // Priority search. The loop scans from the highest index down, so the
    // lowest matching index is the last one assigned and wins.
    always_comb begin
        for (int p = 0; p < int'(NrPorts); p++) begin
            lk_hit[p]  = 1'b0;
            lk_attr[p] = DefaultAttr;
            lk_idx[p]  = '0;
            for (int r = int'(NrRules) - 1; r >= 0; r--) begin
                if (rule_match(lk_addr_i[p*AddrWidth +: AddrWidth],
                               rule_base_q[r], rule_len_q[r])) begin
                    lk_hit[p]  = 1'b1;
                    lk_attr[p] = rule_attr_q[r];
                    lk_idx[p]  = IdxW'(r);
                end
            end
        end
    end

    assign lk_ready_o = ~rsp_valid_q | rsp_ready_i;
    assign lk_accept  = lk_valid_i & lk_ready_o;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_attr_d  = rsp_attr_q;
        rsp_hit_d   = rsp_hit_q;
        rsp_idx_d   = rsp_idx_q;
        for (int p = 0; p < int'(NrPorts); p++) begin
            if (lk_accept[p]) begin
                rsp_valid_d[p] = 1'b1;
                rsp_attr_d[p]  = lk_attr[p];
                rsp_hit_d[p]   = lk_hit[p];
                rsp_idx_d[p]   = lk_idx[p];
            end else if (rsp_ready_i[p]) begin
                rsp_valid_d[p] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 0; r < int'(NrRules); r++) begin
                rule_base_q[r] <= '0;
                rule_len_q[r]  <= '0;
                rule_attr_q[r] <= '0;
            end
            rule_lock_q <= '0;
            cfg_err_q   <= 1'b0;
            rsp_valid_q <= '0;
            rsp_attr_q  <= '0;
            rsp_hit_q   <= '0;
            rsp_idx_q   <= '0;
        end else begin
            for (int r = 0; r < int'(NrRules); r++) begin
                rule_base_q[r] <= rule_base_d[r];
                rule_len_q[r]  <= rule_len_d[r];
                rule_attr_q[r] <= rule_attr_d[r];
            end
            rule_lock_q <= rule_lock_d;
            cfg_err_q   <= cfg_err_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_attr_q  <= rsp_attr_d;
            rsp_hit_q   <= rsp_hit_d;
            rsp_idx_q   <= rsp_idx_d;
        end
    end

    assign cfg_err_o   = cfg_err_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_attr_o  = rsp_attr_q;
    assign rsp_hit_o   = rsp_hit_q;
    assign rsp_idx_o   = rsp_idx_q;

`ifdef REGION_ATTR_MISS_CNT_EN
    logic [NrPorts-1:0][31:0] miss_cnt_q, miss_cnt_d;

    // The counter holds at all-ones instead of wrapping.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        for (int p = 0; p < int'(NrPorts); p++) begin
            if (lk_accept[p] && !lk_hit[p] && (miss_cnt_q[p] != 32'hFFFF_FFFF)) begin
                miss_cnt_d[p] = miss_cnt_q[p] + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_region_attr_table.sv
// Testbench for region_attr_table.
//
// The bench keeps a rule-level reference model of the table, the response
// registers and the miss counters. It compares every DUT output against this
// model on each falling clock edge. Directed scenarios also check literal
// values that were worked out by hand. The miss-counter scenario is compiled
// only when REGION_ATTR_MISS_CNT_EN is defined.
module tb_region_attr_table;

    localparam int NR = 8;
    localparam int NP = 2;
    localparam int AW = 64;
    localparam int IW = 3;

    logic            clk = 1'b0;
    logic            rstN;
    logic            cfgReq;
    logic [IW-1:0]   cfgIdx;
    logic [AW-1:0]   cfgBase;
    logic [AW-1:0]   cfgLen;
    logic [2:0]      cfgAttr;
    logic            cfgLock;
    logic            cfgClear;
    logic            cfgErr;
    logic [NP-1:0]   lkValid;
    logic [NP-1:0]   lkReady;
    logic [NP*AW-1:0] lkAddr;
    logic [NP-1:0]   rspValid;
    logic [NP-1:0]   rspReady;
    logic [NP*3-1:0] rspAttr;
    logic [NP-1:0]   rspHit;
    logic [NP*IW-1:0] rspIdx;
`ifdef REGION_ATTR_MISS_CNT_EN
    logic [NP*32-1:0] missCnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    region_attr_table dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .cfg_req_i   (cfgReq),
        .cfg_idx_i   (cfgIdx),
        .cfg_base_i  (cfgBase),
        .cfg_len_i   (cfgLen),
        .cfg_attr_i  (cfgAttr),
        .cfg_lock_i  (cfgLock),
        .cfg_clear_i (cfgClear),
        .cfg_err_o   (cfgErr),
        .lk_valid_i  (lkValid),
        .lk_ready_o  (lkReady),
        .lk_addr_i   (lkAddr),
        .rsp_valid_o (rspValid),
        .rsp_ready_i (rspReady),
        .rsp_attr_o  (rspAttr),
        .rsp_hit_o   (rspHit),
        .rsp_idx_o   (rspIdx)
`ifdef REGION_ATTR_MISS_CNT_EN
        , .miss_cnt_o (missCnt)
`endif
    );

    // Reference model state
    logic [AW-1:0] mBase [NR];
    logic [AW-1:0] mLen  [NR];
    logic [2:0]    mAttr [NR];
    logic          mLock [NR];
    logic          expValid [NP];
    logic [2:0]    expAttr  [NP];
    logic          expHit   [NP];
    int            expIdx   [NP];
    logic          expErr;
    logic [31:0]   expMiss  [NP];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // An address lies in a rule when its offset from the base is smaller
    // than the length. The first rule that matches, in index order, wins.
    task automatic modelLookup(input logic [AW-1:0] addr, output logic [2:0] a, output logic h, output int idx);
        logic found;
        found = 1'b0;
        a = 3'b001;
        h = 1'b0;
        idx = 0;
        for (int r = 0; r < NR; r++) begin
            if (!found && mLen[r] != 0 && addr >= mBase[r] && (addr - mBase[r]) < mLen[r]) begin
                found = 1'b1;
                a = mAttr[r];
                h = 1'b1;
                idx = r;
            end
        end
    endtask

    // Model update. Lookups use the table as it was before this edge's
    // write or clear is applied.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int r = 0; r < NR; r++) begin
                mBase[r] = '0; mLen[r] = '0; mAttr[r] = '0; mLock[r] = 1'b0;
            end
            for (int p = 0; p < NP; p++) begin
                expValid[p] = 1'b0; expAttr[p] = '0; expHit[p] = 1'b0; expIdx[p] = 0; expMiss[p] = '0;
            end
            expErr = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                logic [2:0] a;
                logic h;
                int idx;
                if (lkValid[p] && (!expValid[p] || rspReady[p])) begin
                    modelLookup(lkAddr[p*AW +: AW], a, h, idx);
                    expValid[p] = 1'b1; expAttr[p] = a; expHit[p] = h; expIdx[p] = idx;
                    if (!h && expMiss[p] != 32'hFFFF_FFFF) expMiss[p] = expMiss[p] + 1;
                end else if (rspReady[p]) begin
                    expValid[p] = 1'b0;
                end
            end
            expErr = cfgReq && mLock[cfgIdx];
            if (cfgClear) begin
                for (int r = 0; r < NR; r++) begin
                    if (!mLock[r]) begin mBase[r] = '0; mLen[r] = '0; mAttr[r] = '0; end
                end
            end
            if (cfgReq && !mLock[cfgIdx]) begin
                mBase[cfgIdx] = cfgBase; mLen[cfgIdx] = cfgLen;
                mAttr[cfgIdx] = cfgAttr; mLock[cfgIdx] = cfgLock;
            end
        end
    end

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (rstN) begin
            for (int p = 0; p < NP; p++) begin
                checkOutput($sformatf("cmp_valid%0d", p), rspValid[p], expValid[p]);
                checkOutput($sformatf("cmp_ready%0d", p), lkReady[p], !expValid[p] || rspReady[p]);
                if (expValid[p]) begin
                    checkOutput($sformatf("cmp_attr%0d", p), rspAttr[p*3 +: 3], expAttr[p]);
                    checkOutput($sformatf("cmp_hit%0d", p), rspHit[p], expHit[p]);
                    checkOutput($sformatf("cmp_idx%0d", p), rspIdx[p*IW +: IW], expIdx[p]);
                end
`ifdef REGION_ATTR_MISS_CNT_EN
                checkOutput($sformatf("cmp_miss%0d", p), missCnt[p*32 +: 32], expMiss[p]);
`endif
            end
            checkOutput("cmp_cfg_err", cfgErr, expErr);
        end
    end

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input int idx, input logic [AW-1:0] base, input logic [AW-1:0] len,
                            input logic [2:0] attr, input logic lock);
        cfgReq = 1'b1; cfgIdx = IW'(idx); cfgBase = base; cfgLen = len; cfgAttr = attr; cfgLock = lock;
        applyStimulus();
        cfgReq = 1'b0; cfgLock = 1'b0;
    endtask

    task automatic lookup(input int p, input logic [AW-1:0] addr);
        lkValid[p] = 1'b1;
        lkAddr[p*AW +: AW] = addr;
        applyStimulus();
        lkValid[p] = 1'b0;
    endtask

    task automatic expectRsp(input string name, input int p, input logic hit, input int idx, input logic [2:0] attr);
        checkOutput({name, "_valid"}, rspValid[p], 1'b1);
        checkOutput({name, "_hit"}, rspHit[p], hit);
        checkOutput({name, "_idx"}, rspIdx[p*IW +: IW], idx);
        checkOutput({name, "_attr"}, rspAttr[p*3 +: 3], attr);
    endtask

    initial begin
        rstN = 1'b0; cfgReq = 1'b0; cfgIdx = '0; cfgBase = '0; cfgLen = '0; cfgAttr = '0;
        cfgLock = 1'b0; cfgClear = 1'b0; lkValid = '0; lkAddr = '0; rspReady = 2'b11;
        repeat (2) applyStimulus();
        checkOutput("rst_valid", rspValid, 0);
        checkOutput("rst_ready", lkReady, 2'b11);
        checkOutput("rst_err", cfgErr, 0);
        checkOutput("rst_hit", rspHit, 0);
        checkOutput("rst_attr", rspAttr, 0);
        checkOutput("rst_idx", rspIdx, 0);
        rstN = 1'b1;
        applyStimulus();

        // Priority: rules 2 and 5 overlap, and the lower index wins
        cfgWrite(2, 64'h8000_0000, 64'h4000_0000, 3'b011, 1'b0);
        cfgWrite(5, 64'h8000_0000, 64'h1000, 3'b100, 1'b0);
        lookup(0, 64'h8000_0800);
        expectRsp("prio", 0, 1'b1, 2, 3'b011);

        // Boundaries
        cfgWrite(0, 64'h1_0000, 64'h1_0000, 3'b110, 1'b0);
        lookup(0, 64'h1_0000);
        expectRsp("bnd_lo", 0, 1'b1, 0, 3'b110);
        lookup(0, 64'h1_FFFF);
        expectRsp("bnd_hi", 0, 1'b1, 0, 3'b110);
        lookup(0, 64'h2_0000);
        expectRsp("bnd_end", 0, 1'b0, 0, 3'b001);
        cfgWrite(1, 64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b101, 1'b0);
        lookup(0, 64'hFFFF_FFFF_FFFF_FFFF);
        expectRsp("bnd_top", 0, 1'b1, 1, 3'b101);
        lookup(0, 64'hFFFF_FFFF_FFFF_EFFF);
        expectRsp("bnd_below", 0, 1'b0, 0, 3'b001);

        // Lock: the rewrite and the clear both leave rule 3 unchanged
        cfgWrite(3, 64'h4000_0000, 64'h100, 3'b111, 1'b1);
        checkOutput("lock_first_err", cfgErr, 0);
        cfgWrite(3, 64'h4000_0000, 64'h100, 3'b000, 1'b0);
        checkOutput("lock_rewrite_err", cfgErr, 1);
        cfgClear = 1'b1;
        applyStimulus();
        cfgClear = 1'b0;
        checkOutput("lock_clear_err", cfgErr, 0);
        lookup(0, 64'h4000_0010);
        expectRsp("lock_kept", 0, 1'b1, 3, 3'b111);
        lookup(0, 64'h8000_0800);
        expectRsp("clr_prio", 0, 1'b0, 0, 3'b001);
        lookup(0, 64'h1_0000);
        expectRsp("clr_r0", 0, 1'b0, 0, 3'b001);

        // Backpressure on port 1 while port 0 streams
        cfgWrite(0, 64'h2000, 64'h1000, 3'b010, 1'b0);
        rspReady = 2'b01;
        lkValid = 2'b11;
        lkAddr[0 +: AW] = 64'h2000;
        lkAddr[AW +: AW] = 64'h2040;
        applyStimulus();
        expectRsp("bp_first1", 1, 1'b1, 0, 3'b010);
        lkAddr[AW +: AW] = 64'h9000;
        for (int i = 0; i < 4; i++) begin
            lkAddr[0 +: AW] = (i % 2 == 1) ? 64'h7000 : 64'h2000 + 64'(i * 8);
            applyStimulus();
            checkOutput("bp_ready1", lkReady[1], 0);
            expectRsp("bp_hold1", 1, 1'b1, 0, 3'b010);
            expectRsp("bp_port0", 0, (i % 2 == 0), 0, (i % 2 == 0) ? 3'b010 : 3'b001);
        end
        rspReady = 2'b11;
        applyStimulus();
        expectRsp("bp_release1", 1, 1'b0, 0, 3'b001);
        lkValid = 2'b00;
        applyStimulus();

        // A lookup in the same cycle as a write sees the old rule
        cfgReq = 1'b1; cfgIdx = 3'd0; cfgBase = 64'h2000; cfgLen = 64'h1000; cfgAttr = 3'b101;
        lkValid[0] = 1'b1; lkAddr[0 +: AW] = 64'h2100;
        applyStimulus();
        cfgReq = 1'b0; lkValid[0] = 1'b0;
        expectRsp("wr_same", 0, 1'b1, 0, 3'b010);
        lookup(0, 64'h2100);
        expectRsp("wr_next", 0, 1'b1, 0, 3'b101);

        // Asynchronous reset in the middle of traffic
        lkValid = 2'b11;
        lkAddr[0 +: AW] = 64'h2000;
        lkAddr[AW +: AW] = 64'h4000_0010;
        repeat (2) applyStimulus();
        @(negedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("arst_valid", rspValid, 0);
        checkOutput("arst_ready", lkReady, 2'b11);
        checkOutput("arst_attr", rspAttr, 0);
        lkValid = 2'b00;
        applyStimulus();
        rstN = 1'b1;
        lookup(0, 64'h8000_0000);
        expectRsp("arst_default", 0, 1'b0, 0, 3'b001);
        cfgWrite(3, 64'h8000_0000, 64'h100, 3'b100, 1'b0);
        checkOutput("arst_unlock_err", cfgErr, 0);
        lookup(0, 64'h8000_0000);
        expectRsp("arst_unlocked", 0, 1'b1, 3, 3'b100);

`ifdef REGION_ATTR_MISS_CNT_EN
        // Miss counters: 5 hits and 10 misses on port 0, then saturation
        rstN = 1'b0;
        applyStimulus();
        rstN = 1'b1;
        cfgWrite(0, 64'h1000, 64'h100, 3'b010, 1'b0);
        lkValid[0] = 1'b1;
        for (int i = 0; i < 15; i++) begin
            lkAddr[0 +: AW] = (i < 5) ? 64'h1000 + 64'(i) : 64'h9000 + 64'(i);
            applyStimulus();
        end
        lkValid[0] = 1'b0;
        applyStimulus();
        checkOutput("miss_cnt0", missCnt[31:0], 32'd10);
        checkOutput("miss_cnt1", missCnt[63:32], 32'd0);
        force dut.miss_cnt_q = 64'h0000_0000_FFFF_FFFF;
        expMiss[0] = 32'hFFFF_FFFF;
        applyStimulus();
        release dut.miss_cnt_q;
        lookup(0, 64'h9000);
        checkOutput("miss_sat", missCnt[31:0], 32'hFFFF_FFFF);
        lookup(0, 64'h9100);
        checkOutput("miss_sat2", missCnt[31:0], 32'hFFFF_FFFF);
`endif

        repeat (2) applyStimulus();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
